// File: rtl/adpcm_codec.sv
// IMA/DVI ADPCM codec with one shared predictor core; sel_rx picks encode or decode.
// One sample per req toggle. ack pulses once the predictor has been updated.
module adpcm_codec (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               sel_rx,
  input  logic signed [15:0] rx_pcm,
  input  logic        [3:0]  rx_adpcm,
  output logic        [3:0]  tx_adpcm,
  output logic signed [15:0] tx_pcm,
  input  logic               req,
  output logic               ack
);

  localparam int DATA_W = 16;

  localparam int STEP_TBL [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  typedef enum logic [1:0] {IDLE, CALC, UPD, ACK} state_t;

  function automatic logic [14:0] step_lut(input logic [6:0] i);
    if (i > 7'd88) step_lut = 15'd32767;
    else           step_lut = 15'(STEP_TBL[i]);
  endfunction

  function automatic logic signed [4:0] idx_adj(input logic [2:0] m);
    case (m)
      3'd4:    idx_adj = 5'sd2;
      3'd5:    idx_adj = 5'sd4;
      3'd6:    idx_adj = 5'sd6;
      3'd7:    idx_adj = 5'sd8;
      default: idx_adj = -5'sd1;
    endcase
  endfunction

  function automatic logic [6:0] clamp_idx_f(input logic signed [7:0] v);
    if (v < 8'sd0)       clamp_idx_f = 7'd0;
    else if (v > 8'sd88) clamp_idx_f = 7'd88;
    else                 clamp_idx_f = v[6:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       sat16 = 16'sh7fff;
    else if (v < -18'sd32768) sat16 = 16'sh8000;
    else                      sat16 = v[DATA_W-1:0];
  endfunction

  // Reconstruction value from step and magnitude; shared by both directions.
  function automatic logic [15:0] vp_calc(input logic [14:0] st, input logic [2:0] m);
    logic [15:0] s16;
    s16     = {1'b0, st};
    vp_calc = s16 >> 3;
    if (m[2]) vp_calc = vp_calc + s16;
    if (m[1]) vp_calc = vp_calc + (s16 >> 1);
    if (m[0]) vp_calc = vp_calc + (s16 >> 2);
  endfunction

  state_t                    state;
  logic                      req_q;
  logic                      toggle;
  logic signed [DATA_W-1:0]  predict;
  logic        [6:0]         idx;
  logic        [14:0]        step;
  logic        [3:0]         delta;
  logic        [15:0]        sigma;
  logic signed [16:0]        diff_s;
  logic        [16:0]        diff;
  logic        [16:0]        rem;
  logic        [16:0]        s17;
  logic        [2:0]         enc_mag;
  logic        [3:0]         nib_in;
  logic        [15:0]        vp_in;
  logic signed [4:0]         adj;
  logic signed [7:0]         idx_sum;
  logic        [6:0]         clamp_idx;
  logic        [14:0]        nst_step;
  logic signed [17:0]        upd_sum;
  logic signed [DATA_W-1:0]  pred_next;

  assign toggle = req ^ req_q;

  // req_q follows req on every clock, including reset and disable, so no stale toggle survives.
  always_ff @(posedge clk) req_q <= req;

  always_comb begin
    diff_s  = {rx_pcm[15], rx_pcm} - {predict[15], predict};
    diff    = diff_s[16] ? 17'(-diff_s) : 17'(diff_s);
    s17     = {2'b00, step};
    rem     = diff;
    enc_mag = 3'b000;
    if (rem >= s17) begin
      enc_mag[2] = 1'b1;
      rem        = rem - s17;
    end
    if (rem >= (s17 >> 1)) begin
      enc_mag[1] = 1'b1;
      rem        = rem - (s17 >> 1);
    end
    if (rem >= (s17 >> 2)) enc_mag[0] = 1'b1;
    nib_in = sel_rx ? rx_adpcm : {diff_s[16], enc_mag};
    vp_in  = vp_calc(step, nib_in[2:0]);
  end

  always_comb begin
    adj       = idx_adj(delta[2:0]);
    idx_sum   = $signed({1'b0, idx}) + $signed({{3{adj[4]}}, adj});
    clamp_idx = clamp_idx_f(idx_sum);
    nst_step  = step_lut(clamp_idx);
    upd_sum   = delta[3] ? $signed({{2{predict[15]}}, predict}) - $signed({2'b00, sigma})
                         : $signed({{2{predict[15]}}, predict}) + $signed({2'b00, sigma});
    pred_next = sat16(upd_sum);
  end

  // CALC -> UPD boundary: nibble and reconstruction value captured for the update.
  always_ff @(posedge clk) begin
    if (state == CALC) begin
      delta <= nib_in;
      sigma <= vp_in;
    end
  end

  // UPD -> ACK boundary: predictor, index and outputs commit together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ack      <= 1'b0;
      predict  <= '0;
      idx      <= '0;
      step     <= 15'd7;
      tx_adpcm <= '0;
      tx_pcm   <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      ack     <= 1'b0;
      predict <= '0;
      idx     <= '0;
      step    <= 15'd7;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (toggle) state <= CALC;
        CALC: state <= UPD;
        UPD: begin
          predict  <= pred_next;
          tx_pcm   <= pred_next;
          idx      <= clamp_idx;
          step     <= nst_step;
          tx_adpcm <= delta;
          state    <= ACK;
        end
        ACK: begin
          ack   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_codec.sv
// Scoreboard bench for adpcm_codec: an integer IMA reference model predicts each
// transaction's outputs; a monitor compares them whenever ack pulses.
module tb_adpcm_codec;

  logic               clk = 1'b0;
  logic               rstn;
  logic               enable;
  logic               sel_rx;
  logic signed [15:0] rx_pcm;
  logic        [3:0]  rx_adpcm;
  logic        [3:0]  tx_adpcm;
  logic signed [15:0] tx_pcm;
  logic               req;
  logic               ack;

  adpcm_codec dut (
    .clk(clk), .rstn(rstn), .enable(enable), .sel_rx(sel_rx),
    .rx_pcm(rx_pcm), .rx_adpcm(rx_adpcm), .tx_adpcm(tx_adpcm), .tx_pcm(tx_pcm),
    .req(req), .ack(ack)
  );

  always #5 clk = ~clk;

  localparam int STEPS [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  localparam int IDXT [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  localparam int NSWEEP = 2000;

  typedef struct {
    int nib;
    int pcm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pred = 0;
  int   m_idx  = 0;
  int   trace_nib [NSWEEP];
  int   trace_pcm [NSWEEP];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_apply(input int sgn, input int mag, input int vp);
    m_pred = sgn ? m_pred - vp : m_pred + vp;
    if (m_pred > 32767)  m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    m_idx = m_idx + IDXT[mag];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 88) m_idx = 88;
  endfunction

  // Encoder: successive approximation with a running reconstruction value.
  function automatic int model_enc(input int pcm);
    int d, st, mag, vp, sgn;
    d   = pcm - m_pred;
    sgn = (d < 0) ? 1 : 0;
    if (d < 0) d = -d;
    st  = STEPS[m_idx];
    vp  = st / 8;
    mag = 0;
    if (d >= st)     begin mag += 4; d -= st;     vp += st;     end
    if (d >= st / 2) begin mag += 2; d -= st / 2; vp += st / 2; end
    if (d >= st / 4) begin mag += 1;              vp += st / 4; end
    model_apply(sgn, mag, vp);
    return sgn * 8 + mag;
  endfunction

  function automatic int model_dec(input int nib);
    int st, mag, vp;
    st  = STEPS[m_idx];
    mag = nib % 8;
    vp  = st / 8 + ((mag / 4) % 2) * st + ((mag / 2) % 2) * (st / 2) + (mag % 2) * (st / 4);
    model_apply(nib / 8, mag, vp);
    return m_pred;
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack) begin
      if (q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("tx_adpcm", int'(tx_adpcm), e.nib);
        check("tx_pcm", int'(tx_pcm), e.pcm);
      end
    end
  end

  task automatic fresh_enable(input logic dec);
    @(negedge clk);
    enable = 1'b0;
    sel_rx = dec;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    m_pred = 0;
    m_idx  = 0;
  endtask

  task automatic txn(input int nib_in, input int pcm_in, input int e_nib, input int e_pcm,
                     input bit glitch);
    int lat;
    bit got;
    exp_t e;
    e.nib = e_nib;
    e.pcm = e_pcm;
    q.push_back(e);
    rx_pcm   = 16'(pcm_in);
    rx_adpcm = 4'(nib_in);
    req      = ~req;
    lat      = 0;
    got      = 1'b0;
    if (glitch) begin
      @(negedge clk);
      lat++;
      req = ~req;
    end
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack) got = 1'b1;
    end
    check("ack_latency", lat, 4);
    if (got) begin
      @(negedge clk);
      check("ack_pulse_width", int'(ack), 0);
    end
  endtask

  task automatic enc(input int pcm);
    int n;
    n = model_enc(pcm);
    txn(0, pcm, n, m_pred, 1'b0);
  endtask

  task automatic dec(input int nib);
    int p;
    p = model_dec(nib);
    txn(nib, 0, nib, p, 1'b0);
  endtask

  initial begin
    int cur;
    logic [15:0] r;
    rstn = 1'b0; enable = 1'b0; sel_rx = 1'b0; req = 1'b0; rx_pcm = '0; rx_adpcm = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", int'(ack), 0);
    check("reset_tx_pcm", int'(tx_pcm), 0);
    check("reset_tx_adpcm", int'(tx_adpcm), 0);
    rstn = 1'b1;

    // Single encode from a fresh stream.
    fresh_enable(1'b0);
    enc(100);
    check("t1_nibble", int'(tx_adpcm), 7);
    check("t1_pcm", int'(tx_pcm), 11);
    check("t1_idx", int'(dut.idx), 8);

    fresh_enable(1'b0);
    enc(-100);
    check("t2_nibble", int'(tx_adpcm), 15);
    check("t2_pcm", int'(tx_pcm), -11);
    enc(0);

    fresh_enable(1'b1);
    dec(7);
    check("t3_pcm_a", int'(tx_pcm), 11);
    dec(0);
    check("t3_pcm_b", int'(tx_pcm), 13);
    check("t3_idx", int'(dut.idx), 7);

    // Saturation in both directions.
    fresh_enable(1'b1);
    for (int i = 0; i < 200; i++) dec(7);
    check("sat_pos_pcm", int'(tx_pcm), 32767);
    check("sat_pos_idx", int'(dut.idx), 88);
    for (int i = 0; i < 200; i++) dec(15);
    check("sat_neg_pcm", int'(tx_pcm), -32768);

    // Random encode sweep, then decode its nibbles against the encoder trace.
    fresh_enable(1'b0);
    cur = 0;
    for (int i = 0; i < NSWEEP; i++) begin
      if (i % 5 == 0) begin
        r   = 16'($urandom);
        cur = int'($signed(r));
      end else begin
        cur = cur + int'($urandom_range(0, 4000)) - 2000;
        if (cur > 32767)  cur = 32767;
        if (cur < -32768) cur = -32768;
      end
      trace_nib[i] = model_enc(cur);
      trace_pcm[i] = m_pred;
      txn(0, cur, trace_nib[i], trace_pcm[i], 1'b0);
    end
    fresh_enable(1'b1);
    for (int i = 0; i < NSWEEP; i++) txn(trace_nib[i], 0, trace_nib[i], trace_pcm[i], 1'b0);

    // Disable mid-transaction: no ack, stream restarts from initial state.
    fresh_enable(1'b0);
    enc(3000);
    rx_pcm = 16'sd500;
    req = ~req;
    @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    m_pred = 0;
    m_idx  = 0;
    enc(100);
    check("dis_restart_pcm", int'(tx_pcm), 11);

    // Reset between toggle and ack: aborted, outputs cleared.
    rx_pcm = 16'sd1000;
    req = ~req;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_abort_pcm", int'(tx_pcm), 0);
    check("rst_abort_idx", int'(dut.idx), 0);
    m_pred = 0;
    m_idx  = 0;
    enc(-100);

    // Extra toggle during CALC is ignored: one ack only.
    begin
      int n;
      n = model_enc(2500);
      txn(0, 2500, n, m_pred, 1'b1);
    end
    repeat (8) @(negedge clk);
    enc(-2500);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
